// File: rtl/param_memory_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package param_memory_pkg;

  typedef enum logic {ST_INIT, ST_READY} mem_state_e;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the replication helper can produce; callers slice down to DATA_W.
  localparam int REPL_MAX_W = 1024;

  function automatic logic [REPL_MAX_W-1:0] repl_byte(input logic [7:0] b);
    return {(REPL_MAX_W/8){b}};
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid/data/err, flushed by async reset.
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [RD_LAT-1:0] valid_reg;
  logic [RD_LAT-1:0] err_reg;
  logic [DATA_W-1:0] data_reg [RD_LAT];

  // Data stages only load behind a valid beat, so the last stage holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      err_reg   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      err_reg[0]   <= in_valid & in_err;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        err_reg[i]   <= err_reg[i-1];
        if (valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[RD_LAT-1];
  assign out_err   = err_reg[RD_LAT-1];
  assign out_data  = data_reg[RD_LAT-1];

endmodule

// File: rtl/param_memory.sv
// Parametrised single-port RAM with byte enables, configurable read latency,
// read-during-write selection, out-of-range flagging and a hardware init sweep.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 3,
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  INIT_VAL = 8'hCA,
  parameter int          RD_LAT   = 1,
  parameter int          RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic                init_req,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                rerr
);

  localparam int                NBYTES     = DATA_W / 8;
  localparam logic [REPL_MAX_W-1:0] INIT_FULL = repl_byte(INIT_VAL);
  localparam logic [DATA_W-1:0] INIT_WORD  = INIT_FULL[DATA_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_IDX   = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_e        state_reg;
  logic [ADDR_W:0]   idx_reg;
  logic              ready_reg;

  logic              in_range;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;

  assign in_range  = {1'b0, addr} < DEPTH_EXT;
  assign wr_accept = wr_en & ready_reg;
  assign rd_accept = rd_en & ready_reg;
  assign old_word  = in_range ? mem[addr] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = wbe[gi] ? wdata[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  // Single port: a simultaneous write always targets the read address.
  assign rd_word = (RDW_MODE == RDW_WRITE_FIRST && wr_accept) ? merged_word : old_word;

  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      mem[idx_reg[ADDR_W-1:0]] <= INIT_WORD;
    end else if (wr_accept && in_range) begin
      mem[addr] <= merged_word;
    end
  end

  // idx_reg is one bit wider than addr so a full 2**ADDR_W sweep ends without wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_INIT;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_READY;
            ready_reg <= 1'b1;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_READY: begin
          if (init_req) begin
            state_reg <= ST_INIT;
            ready_reg <= 1'b0;
            idx_reg   <= '0;
          end
        end
      endcase
    end
  end

  assign ready = ready_reg;

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_accept),
    .in_data   (in_range ? rd_word : '0),
    .in_err    (~in_range),
    .out_valid (rvalid),
    .out_data  (rdata),
    .out_err   (rerr)
  );

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory: three instances cover default, wide/short/write-first,
// and long-latency configurations.
module tb_param_memory;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [2:0]  reset_w, wr_w, rd_w, init_w;
  logic [2:0]  ready_w, rvalid_w, rerr_w;
  logic [2:0]  addr_w  [3];
  logic [31:0] wdata_w [3];
  logic [3:0]  wbe_w   [3];
  logic [7:0]  rdata0, rdata2;
  logic [31:0] rdata1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  param_memory u0 (
    .clk(clk), .reset(reset_w[0]), .addr(addr_w[0]), .wdata(wdata_w[0][7:0]),
    .wbe(wbe_w[0][0:0]), .wr_en(wr_w[0]), .rd_en(rd_w[0]), .init_req(init_w[0]),
    .ready(ready_w[0]), .rdata(rdata0), .rvalid(rvalid_w[0]), .rerr(rerr_w[0])
  );

  param_memory #(.DATA_W(32), .DEPTH(6), .RDW_MODE(1), .RD_LAT(2)) u1 (
    .clk(clk), .reset(reset_w[1]), .addr(addr_w[1]), .wdata(wdata_w[1]),
    .wbe(wbe_w[1]), .wr_en(wr_w[1]), .rd_en(rd_w[1]), .init_req(init_w[1]),
    .ready(ready_w[1]), .rdata(rdata1), .rvalid(rvalid_w[1]), .rerr(rerr_w[1])
  );

  param_memory #(.RD_LAT(3)) u2 (
    .clk(clk), .reset(reset_w[2]), .addr(addr_w[2]), .wdata(wdata_w[2][7:0]),
    .wbe(wbe_w[2][0:0]), .wr_en(wr_w[2]), .rd_en(rd_w[2]), .init_req(init_w[2]),
    .ready(ready_w[2]), .rdata(rdata2), .rvalid(rvalid_w[2]), .rerr(rerr_w[2])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? {24'b0, rdata0} : ((d == 1) ? rdata1 : {24'b0, rdata2});
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] ed, input logic ee);
    exp_t e;
    e.d = ed;
    e.e = ee;
    e.due = cyc + lat_of(d);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Drive one cycle of access on instance d; push an expectation when a read should return.
  task automatic issue(input int d, input logic w, input logic r, input logic ini,
                       input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic push, input logic [31:0] ed, input logic ee);
    wr_w[d]    = w;
    rd_w[d]    = r;
    init_w[d]  = ini;
    addr_w[d]  = a;
    wdata_w[d] = wd;
    wbe_w[d]   = be;
    if (push) push_exp(d, ed, ee);
    @(posedge clk); #1;
    wr_w[d]   = 1'b0;
    rd_w[d]   = 1'b0;
    init_w[d] = 1'b0;
  endtask

  task automatic ready_wait(input int d, input int want, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (ready_w[d]) begin
        n = i;
        break;
      end
    end
    chk(name, n, want);
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    case (d)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    if (n > 0) begin
      case (d)
        0:       e = q0[0];
        1:       e = q1[0];
        default: e = q2[0];
      endcase
    end
    if (rvalid_w[d]) begin
      if (n == 0) begin
        total++;
        bad++;
        $display("FAIL dut%0d unexpected rvalid at cyc %0d: got=1 want=0", d, cyc);
      end else begin
        pop_exp(d);
        $display("dut%0d read cyc=%0d rdata=%h rerr=%b", d, cyc, rdata_of(d), rerr_w[d]);
        chk($sformatf("dut%0d rdata", d), rdata_of(d), e.d);
        chk($sformatf("dut%0d rerr", d), {31'b0, rerr_w[d]}, {31'b0, e.e});
        chk($sformatf("dut%0d latency cycle", d), cyc, e.due);
      end
    end else if (n > 0 && cyc >= e.due) begin
      total++;
      bad++;
      $display("FAIL dut%0d missing rvalid at cyc %0d: got=0 want=1", d, cyc);
      pop_exp(d);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  initial begin
    int first [3];
    reset_w = 3'b000;
    wr_w    = 3'b000;
    rd_w    = 3'b000;
    init_w  = 3'b000;
    for (int d = 0; d < 3; d++) begin
      addr_w[d]  = '0;
      wdata_w[d] = '0;
      wbe_w[d]   = '0;
      first[d]   = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d reset ready", d), {31'b0, ready_w[d]}, 32'h0);
      chk($sformatf("dut%0d reset rvalid", d), {31'b0, rvalid_w[d]}, 32'h0);
      chk($sformatf("dut%0d reset rerr", d), {31'b0, rerr_w[d]}, 32'h0);
      chk($sformatf("dut%0d reset rdata", d), rdata_of(d), 32'h0);
    end

    // Init sweep length equals DEPTH after release.
    reset_w = 3'b111;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (ready_w[d] && first[d] == 0) first[d] = i;
      end
    end
    chk("dut0 init cycles", first[0], 8);
    chk("dut1 init cycles", first[1], 6);
    chk("dut2 init cycles", first[2], 8);

    // Default instance: every word holds the init byte, back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b0, 1'b1, 1'b0, 3'(i), 32'h0, 4'h0, 1'b1, 32'hCA, 1'b0);
    end
    // Read-old-data on a same-cycle write, then the new value is visible.
    issue(0, 1'b1, 1'b1, 1'b0, 3'd5, 32'h5A, 4'h1, 1'b1, 32'hCA, 1'b0);
    issue(0, 1'b0, 1'b1, 1'b0, 3'd5, 32'h0, 4'h0, 1'b1, 32'h5A, 1'b0);
    // Write with its only lane disabled leaves the word alone.
    issue(0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h00, 4'h0, 1'b0, 32'h0, 1'b0);
    issue(0, 1'b0, 1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 1'b1, 32'hCA, 1'b0);

    // Wide instance: partial byte write, write-first, out-of-range.
    issue(1, 1'b1, 1'b0, 1'b0, 3'd2, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b0, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0, 1'b1, 32'hCA22CA44, 1'b0);
    issue(1, 1'b1, 1'b1, 1'b0, 3'd5, 32'h0000005A, 4'hF, 1'b1, 32'h0000005A, 1'b0);
    issue(1, 1'b0, 1'b1, 1'b0, 3'd5, 32'h0, 4'h0, 1'b1, 32'h0000005A, 1'b0);
    issue(1, 1'b1, 1'b1, 1'b0, 3'd3, 32'hAABBCCDD, 4'b0011, 1'b1, 32'hCACACCDD, 1'b0);
    issue(1, 1'b1, 1'b0, 1'b0, 3'd7, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b0, 1'b1, 1'b0, 3'd7, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 1'b1, 32'hCACACACA, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Long-latency instance: init_req on the 2nd of 4 reads; only two are accepted.
    issue(2, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 32'hCA, 1'b0);
    issue(2, 1'b0, 1'b1, 1'b1, 3'd1, 32'h0, 4'h0, 1'b1, 32'hCA, 1'b0);
    chk("dut2 ready after init_req", {31'b0, ready_w[2]}, 32'h0);
    issue(2, 1'b0, 1'b1, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    issue(2, 1'b0, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("dut2 ready mid init", {31'b0, ready_w[2]}, 32'h0);
    reset_w[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("dut2 rvalid in reset", {31'b0, rvalid_w[2]}, 32'h0);
    reset_w[2] = 1'b1;
    ready_wait(2, 8, "dut2 init cycles after mid-init reset");

    // A read in flight is discarded by reset.
    issue(2, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    reset_w[2] = 1'b0;
    @(posedge clk); #1;
    chk("dut2 rvalid after flush", {31'b0, rvalid_w[2]}, 32'h0);
    @(posedge clk); #1;
    reset_w[2] = 1'b1;
    ready_wait(2, 8, "dut2 init cycles after flush");
    issue(2, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 1'b1, 32'hCA, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
